mdu_multicycle: RTL and testbench
=================================

Name: mdu_multicycle

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Serves the pipelined successor of the single-cycle core.
- Sits beside the ALU in EX. Accepts one operation per start pulse, holds busy for a configurable latency, then commits the result to HI/LO.
- The pipeline stalls on busy (or on start) when a later MD instruction arrives.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles from accepted multiply start to HI/LO commit (>=1).
- DIV_CYCLES, 10, cycles from accepted divide start to HI/LO commit (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; qualifies op for MULT/MULTU/DIV/DIVU (and MADD-class ops).
- op  input  4  operation code (package constants).
- a  input  WIDTH  rs operand.
- b  input  WIDTH  rt operand.
- busy  output  1  operation in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- rd_data  output  WIDTH  combinational read: hi when op=MFHI, lo when op=MFLO, else 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, any time): hi=0, lo=0, busy=0, counter=0, pending result discarded. An in-flight operation is aborted and never commits.
- States:
  - IDLE: start=1 with an arithmetic op at edge t loads the counter with N (MULT_CYCLES or DIV_CYCLES). Operands are latched and the result is computed into a pending {h,l}. Go to BUSY; busy=1 after edge t.
  - BUSY: counter decrements each edge. At edge t+N, hi/lo take the pending value, busy falls and the state returns to IDLE. busy is high for exactly N cycles.
- start while busy=1: ignored; no effect on pending result or counter.
- start=0 or a non-arithmetic op: no operation is launched.
- MTHI/MTLO (no start needed):
  - Write a into hi/lo at the edge when busy=0.
  - Ignored when busy=1.
  - op is sampled every cycle; the controller drives NOP otherwise.
- MFHI/MFLO: rd_data reflects the current register. Value is undefined-by-contract while busy; the pipeline must stall. The bench still checks that the old value is shown.
- MULT: signed WIDTHxWIDTH -> 2*WIDTH; hi=upper, lo=lower.
- MULTU: same as MULT, unsigned.
- DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - Most-negative / -1: lo=most-negative, hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (b=0, DIV or DIVU): busy still asserted for DIV_CYCLES; hi/lo left unchanged at commit.
- Start accepted in the same cycle busy falls: busy falls at edge t+N, so a start at edge t+N is accepted (back-to-back). The first result commits and the new operation launches at that edge.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops MADD, MADDU, MSUB, MSUBU are accepted with start and use MULT_CYCLES.
  - At commit, {hi,lo} = {hi,lo} ± product, signed or unsigned per op, modulo 2^(2*WIDTH).
  - The accumulator is the {hi,lo} value at commit time, not at start.
- Undefined: these op codes are treated as NOP; no launch, busy stays 0.

Decomposition:
- Shared package (constants include file alongside the existing one):
  - MDU op codes: NOP, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU.
  - The FSM state encodings IDLE and BUSY.
- One natural sub-module: mdu_arith. It is combinational, takes a, b and op, and produces the 2*WIDTH result plus a div_by_zero flag.
- The top holds the FSM, counter, pending register, HI/LO and the MT/MF logic.

Test Plan:
- MULT a=32'hFFFFFFFE, b=3 -> busy high 5 cycles; then hi=FFFFFFFF, lo=FFFFFFFA. MULTU same operands -> hi=00000002, lo=FFFFFFFA.
- DIV a=-7 (FFFFFFF9), b=2 -> after 10 cycles lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- MTHI 1234, MTLO 5678, then DIVU b=0 -> busy 10 cycles; hi=1234, lo=5678 unchanged. MTLO issued during busy ignored.
- MULT started; second start (DIVU 9/4) at busy cycle 2 is ignored, so only the MULT result commits. Then DIVU issued exactly at the commit edge -> accepted; busy stays high continuously; final lo=2, hi=1.
- MULT 3x4 started; reset pulsed low at busy cycle 3 (asynchronous, mid-cycle) -> busy=0, hi=lo=0 immediately; no commit after release.
- With MDU_MADD_EN: hi=0, lo=FFFFFFFF, then MADDU 1x1 -> hi=1, lo=0. MSUB 1x2 -> hi=0, lo=FFFFFFFE. Without the macro, the same op is NOP: busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/mdu_multicycle_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit: op codes, FSM states, accumulate modes.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU launch ops.
package mdu_multicycle_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_mode_e;

  function automatic logic is_launch_op(input logic [3:0] op);
    logic ok;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: ok = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic acc_mode_e acc_mode_of(input logic [3:0] op);
    acc_mode_e mode;
    case (op)
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: mode = ACC_ADD;
      OP_MSUB, OP_MSUBU: mode = ACC_SUB;
`endif
      default: mode = ACC_NONE;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: signed/unsigned product and quotient/remainder packed as {hi, lo}.
// Divisors are substituted so the divider never sees zero or the MIN / -1 overflow pair.
module mdu_arith
  import mdu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0]      a_sx_s, b_sx_s, a_zx_s, b_zx_s;
  logic signed [WIDTH-1:0] sdivisor_s, squot_s, srem_s;
  logic [WIDTH-1:0]        udivisor_s, uquot_s, urem_s;
  logic                    b_zero_s, overflow_s;

  // Operand extension, safe divisors and result selection by op.
  always_comb begin
    a_sx_s     = {{WIDTH{a[WIDTH-1]}}, a};
    b_sx_s     = {{WIDTH{b[WIDTH-1]}}, b};
    a_zx_s     = {{WIDTH{1'b0}}, a};
    b_zx_s     = {{WIDTH{1'b0}}, b};
    b_zero_s   = (b == '0);
    overflow_s = (a == MOST_NEG) && (b == '1);

    // MIN / 1 yields quotient MIN and remainder 0, exactly the overflow answer.
    if (b_zero_s || overflow_s) begin
      sdivisor_s = WIDTH'(1);
    end else begin
      sdivisor_s = b;
    end
    if (b_zero_s) begin
      udivisor_s = WIDTH'(1);
    end else begin
      udivisor_s = b;
    end

    squot_s = $signed(a) / sdivisor_s;
    srem_s  = $signed(a) % sdivisor_s;
    uquot_s = a / udivisor_s;
    urem_s  = a % udivisor_s;

    result      = '0;
    div_by_zero = 1'b0;
    case (op)
      OP_MULT, OP_MADD, OP_MSUB:    result = a_sx_s * b_sx_s;
      OP_MULTU, OP_MADDU, OP_MSUBU: result = a_zx_s * b_zx_s;
      OP_DIV: begin
        result      = {srem_s, squot_s};
        div_by_zero = b_zero_s;
      end
      OP_DIVU: begin
        result      = {urem_s, uquot_s};
        div_by_zero = b_zero_s;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with architectural HI/LO; result is computed at launch and
// committed after a fixed latency. MDU_MADD_EN enables multiply-accumulate ops (accumulate at commit).
module mdu_multicycle
  import mdu_multicycle_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int PW         = 2 * WIDTH;

  mdu_state_e       state_r;
  logic             busy_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PW-1:0]    pend_r;
  logic             pend_dz_r;
  acc_mode_e        pend_acc_r;
  logic [WIDTH-1:0] hi_r, lo_r;

  logic [PW-1:0]    arith_res_s;
  logic             arith_dz_s;
  logic             commit_s, accept_s;
  logic [CNT_W-1:0] cycles_s;
  logic [PW-1:0]    commit_val_s;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op          (op),
    .a           (a),
    .b           (b),
    .result      (arith_res_s),
    .div_by_zero (arith_dz_s)
  );

  // Commit/accept decode; a launch is also accepted on the commit edge for back-to-back issue.
  always_comb begin
    commit_s = (state_r == ST_BUSY) && (cnt_r == CNT_W'(1));
    accept_s = start && is_launch_op(op) && ((state_r == ST_IDLE) || commit_s);
    if (is_div_op(op)) begin
      cycles_s = CNT_W'(DIV_CYCLES);
    end else begin
      cycles_s = CNT_W'(MULT_CYCLES);
    end
    case (pend_acc_r)
      ACC_ADD: commit_val_s = {hi_r, lo_r} + pend_r;
      ACC_SUB: commit_val_s = {hi_r, lo_r} - pend_r;
      default: commit_val_s = pend_r;
    endcase
  end

  // Controller FSM, latency counter, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      cnt_r      <= '0;
      pend_r     <= '0;
      pend_dz_r  <= 1'b0;
      pend_acc_r <= ACC_NONE;
      hi_r       <= '0;
      lo_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r    <= ST_BUSY;
            busy_r     <= 1'b1;
            cnt_r      <= cycles_s;
            pend_r     <= arith_res_s;
            pend_dz_r  <= arith_dz_s;
            pend_acc_r <= acc_mode_of(op);
          end else if (op == OP_MTHI) begin
            hi_r <= a;
          end else if (op == OP_MTLO) begin
            lo_r <= a;
          end
        end
        ST_BUSY: begin
          if (commit_s) begin
            // A divide by zero keeps the architectural HI/LO untouched.
            if (!pend_dz_r) begin
              hi_r <= commit_val_s[PW-1:WIDTH];
              lo_r <= commit_val_s[WIDTH-1:0];
            end
            if (accept_s) begin
              cnt_r      <= cycles_s;
              pend_r     <= arith_res_s;
              pend_dz_r  <= arith_dz_s;
              pend_acc_r <= acc_mode_of(op);
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              cnt_r   <= '0;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Move-from read port, combinational on op.
  always_comb begin
    if (op == OP_MFHI) begin
      rd_data = hi_r;
    end else if (op == OP_MFLO) begin
      rd_data = lo_r;
    end else begin
      rd_data = '0;
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Randomized self-checking bench for mdu_multicycle against a plain-arithmetic HI/LO model.
// Follows MDU_MADD_EN the same way as the design build.
module tb_mdu_multicycle;
  import mdu_multicycle_pkg::*;

  localparam int W        = 32;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  a, b;
  logic          busy;
  logic [W-1:0]  hi, lo, rd_data;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [W-1:0]  m_hi = '0;
  logic [W-1:0]  m_lo = '0;

  mdu_multicycle #(.WIDTH(W), .MULT_CYCLES(MULT_CYC), .DIV_CYCLES(DIV_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [3:0] o);
    case (o)
      OP_MULT, OP_MULTU: return MULT_CYC;
      OP_DIV, OP_DIVU:   return DIV_CYC;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return MULT_CYC;
`endif
      default: return 0;
    endcase
  endfunction

  // Architectural effect of one completed operation on the model HI/LO.
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, acc;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = 64'(x);
    uy  = 64'(y);
    acc = {m_hi, m_lo};
    case (o)
      OP_MULT:  {m_hi, m_lo} = 64'(sx * sy);
      OP_MULTU: {m_hi, m_lo} = ux * uy;
      OP_DIV: if (y != 0) begin
        q = sx / sy;
        r = sx % sy;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      OP_DIVU: if (y != 0) begin
        m_lo = x / y;
        m_hi = x % y;
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {m_hi, m_lo} = acc + 64'(sx * sy);
      OP_MADDU: {m_hi, m_lo} = acc + ux * uy;
      OP_MSUB:  {m_hi, m_lo} = acc - 64'(sx * sy);
      OP_MSUBU: {m_hi, m_lo} = acc - ux * uy;
`endif
      default: ;
    endcase
  endtask

  task automatic count_busy(inout int n);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Launch one op, measure busy length, compare committed HI/LO.
  task automatic run(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    n = 0;
    count_busy(n);
    check({tag, "_cyc"}, 64'(n), 64'(exp_cycles(o)));
    if (exp_cycles(o) != 0) model(o, x, y);
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  task automatic mt(input logic [3:0] o, input logic [W-1:0] x);
    @(negedge clk);
    op = o; a = x;
    @(negedge clk);
    op = OP_NOP;
    if (o == OP_MTHI) m_hi = x;
    else m_lo = x;
  endtask

  task automatic check_rd(input string tag);
    op = OP_MFHI; #1;
    check({tag, "_mfhi"}, 64'(rd_data), 64'(m_hi));
    op = OP_MFLO; #1;
    check({tag, "_mflo"}, 64'(rd_data), 64'(m_lo));
    op = OP_NOP; #1;
    check({tag, "_nop_rd"}, 64'(rd_data), 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  logic [3:0] ops [8] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; op = OP_NOP; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;

    run(OP_MULT, 32'hFFFF_FFFE, 32'd3, "mult");
    run(OP_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run(OP_DIVU, 32'd7, 32'd2, "divu");
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check_rd("rd_after_div");

    // Divide by zero with an MTLO and an MFHI read while busy.
    mt(OP_MTHI, 32'd1234);
    mt(OP_MTLO, 32'd5678);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd55; b = '0;
    @(negedge clk);
    start = 1'b0; op = OP_MTLO; a = 32'hDEAD;
    check("dz_busy1", 64'(busy), 64'd1);
    n = 1;
    @(negedge clk);
    op = OP_MFHI; #1;
    check("mfhi_busy", 64'(rd_data), 64'(m_hi));
    op = OP_NOP;
    count_busy(n);
    check("dz_cyc", 64'(n), 64'(DIV_CYC));
    check("dz_hi", 64'(hi), 64'd1234);
    check("dz_lo", 64'(lo), 64'd5678);

    // Start during busy is ignored.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd7; b = 32'hFFFF_FFFA;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    n = 1;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd4;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    n = 2;
    count_busy(n);
    model(OP_MULT, 32'd7, 32'hFFFF_FFFA);
    check("ign_cyc", 64'(n), 64'(MULT_CYC));
    check("ign_hi", 64'(hi), 64'(m_hi));
    check("ign_lo", 64'(lo), 64'(m_lo));

    // Back-to-back: DIVU issued on the MULT commit edge.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'h10; b = 32'h20;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    n = 0;
    for (int i = 1; i <= MULT_CYC; i++) begin
      if (busy) n++;
      if (i == MULT_CYC) begin
        start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd4;
      end
      @(negedge clk);
    end
    start = 1'b0; op = OP_NOP;
    check("b2b_first_cyc", 64'(n), 64'(MULT_CYC));
    check("b2b_busy_cont", 64'(busy), 64'd1);
    model(OP_MULT, 32'h10, 32'h20);
    check("b2b_first_hi", 64'(hi), 64'(m_hi));
    check("b2b_first_lo", 64'(lo), 64'(m_lo));
    n = 0;
    count_busy(n);
    check("b2b_second_cyc", 64'(n), 64'(DIV_CYC));
    check("b2b_second_hi", 64'(hi), 64'd1);
    check("b2b_second_lo", 64'(lo), 64'd2);

    // Asynchronous reset mid-flight aborts the multiply.
    mt(OP_MTHI, 32'hABCD);
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("arst_post_busy", 64'(busy), 64'd0);
    check("arst_post_hi", 64'(hi), 64'd0);
    check("arst_post_lo", 64'(lo), 64'd0);

    // Multiply-accumulate ops (NOPs when the feature is disabled).
    mt(OP_MTHI, 32'd0);
    mt(OP_MTLO, 32'hFFFF_FFFF);
    run(OP_MADDU, 32'd1, 32'd1, "maddu");
    run(OP_MSUB, 32'd1, 32'd2, "msub");

    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [W-1:0] x, y;
      sel = $urandom_range(0, 10);
      x = pick();
      y = pick();
      if (sel < 8) run(ops[sel], x, y, "rnd");
      else if (sel == 8) mt(OP_MTHI, x);
      else if (sel == 9) mt(OP_MTLO, x);
      else check_rd("rnd_rd");
    end
    check_rd("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
